// File: rtl/fifo_drain_serializer_pkg.sv
// Shared widths and types for the FIFO drain serializer.
package fifo_drain_pkg;

  localparam int unsigned IN_WIDTH   = 256;
  localparam int unsigned OUT_WIDTH  = 64;
  localparam int unsigned BEATS      = IN_WIDTH / OUT_WIDTH;
  localparam int unsigned BEAT_IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef logic [1:0] occ_t;

  // Slots held by buffered words plus the in-flight pop, minus a head retiring this cycle.
  function automatic logic [1:0] slots_used(input occ_t occ, input logic pend, input logic retire);
    return occ + 2'(pend) - 2'(retire);
  endfunction

endpackage

// File: rtl/fifo_drain_serializer_if.sv
// FIFO read port plus beat stream; master is the serializer side.
interface fifo_drain_serializer_if #(
  parameter int unsigned IN_WIDTH  = fifo_drain_pkg::IN_WIDTH,
  parameter int unsigned OUT_WIDTH = fifo_drain_pkg::OUT_WIDTH
) ();

  logic                 fifoEmpty;
  logic                 fifoPop;
  logic [IN_WIDTH-1:0]  fifoData;
  logic                 txValid;
  logic                 txReady;
  logic [OUT_WIDTH-1:0] txData;
  logic                 txLast;

  modport master (
    input  fifoEmpty, fifoData, txReady,
    output fifoPop, txValid, txData, txLast
  );

  modport slave (
    output fifoEmpty, fifoData, txReady,
    input  fifoPop, txValid, txData, txLast
  );

endinterface

// File: rtl/fifo_drain_serializer_word_buffer.sv
// Two-entry head/tail word buffer: capture into first free slot, retire head, flush.
module drain_word_buffer #(
  parameter int unsigned W = fifo_drain_pkg::IN_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 capture,
  input  logic [W-1:0]         cap_data,
  input  logic                 retire,
  input  logic                 flush,
  output logic [W-1:0]         head,
  output fifo_drain_pkg::occ_t occ
);
  import fifo_drain_pkg::*;

  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  occ_t         occ_q, occ_d, occ_r;

  // A retiring head frees its slot before the captured word is placed.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_r  = occ_q - occ_t'(retire);
    occ_d  = occ_r;
    if (flush) begin
      occ_d = '0;
    end else begin
      if (retire) head_d = tail_q;
      if (capture) begin
        if (occ_r == '0) head_d = cap_data;
        else             tail_d = cap_data;
        occ_d = occ_r + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  assign head = head_q;
  assign occ  = occ_q;

endmodule

// File: rtl/fifo_drain_serializer.sv
// Drains the RAM FIFO read port and serializes each word into LSB-first beats.
// Optional accepted-beat counter port beatCount under `DRAIN_BEAT_COUNT_EN.
module fifo_drain_serializer #(
  parameter int unsigned IN_WIDTH  = fifo_drain_pkg::IN_WIDTH,
  parameter int unsigned OUT_WIDTH = fifo_drain_pkg::OUT_WIDTH
) (
  input  logic                     clockCore,
  input  logic                     resetCore,
  input  logic                     drainEnable,
  input  logic                     flush,
  fifo_drain_serializer_if.master  bus,
  output logic                     busy
`ifdef DRAIN_BEAT_COUNT_EN
  , output logic [15:0]            beatCount
`endif
);
  import fifo_drain_pkg::*;

  localparam int unsigned NBEATS = IN_WIDTH / OUT_WIDTH;
  localparam int unsigned IDX_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  logic              pop_pending_q, pop_pending_d;
  logic [IDX_W-1:0]  beat_idx_q, beat_idx_d;
  logic [IN_WIDTH-1:0] head;
  occ_t              occ;
  logic              accept, last_beat, retire, capture;

  drain_word_buffer #(.W(IN_WIDTH)) u_buf (
    .clk      (clockCore),
    .rst      (resetCore),
    .capture  (capture),
    .cap_data (bus.fifoData),
    .retire   (retire),
    .flush    (flush),
    .head     (head),
    .occ      (occ)
  );

  // Pop gating, beat mux and beat index; the in-flight pop reserves a buffer slot.
  always_comb begin
    bus.txValid   = (occ != '0);
    last_beat     = (beat_idx_q == IDX_W'(NBEATS - 1));
    bus.txLast    = bus.txValid && last_beat;
    bus.txData    = head[32'(beat_idx_q) * OUT_WIDTH +: OUT_WIDTH];
    accept        = bus.txValid && bus.txReady;
    retire        = accept && last_beat;
    capture       = pop_pending_q && !flush;
    bus.fifoPop   = !resetCore && drainEnable && !bus.fifoEmpty && !flush &&
                    (slots_used(occ, pop_pending_q, retire) < 2'd2);
    pop_pending_d = bus.fifoPop;
    busy          = (occ != '0) || pop_pending_q;
    beat_idx_d    = beat_idx_q;
    if (flush || retire) beat_idx_d = '0;
    else if (accept)     beat_idx_d = beat_idx_q + IDX_W'(1);
  end

  always_ff @(posedge clockCore or posedge resetCore) begin
    if (resetCore) begin
      pop_pending_q <= 1'b0;
      beat_idx_q    <= '0;
    end else begin
      pop_pending_q <= pop_pending_d;
      beat_idx_q    <= beat_idx_d;
    end
  end

`ifdef DRAIN_BEAT_COUNT_EN
  logic [15:0] beat_count_q, beat_count_d;

  // Saturating count of accepted beats.
  always_comb begin
    beat_count_d = beat_count_q;
    if (flush)                                  beat_count_d = '0;
    else if (accept && beat_count_q != 16'hFFFF) beat_count_d = beat_count_q + 16'd1;
  end

  always_ff @(posedge clockCore or posedge resetCore) begin
    if (resetCore) beat_count_q <= '0;
    else           beat_count_q <= beat_count_d;
  end

  assign beatCount = beat_count_q;
`endif

endmodule
